edge_window_ctrl: RTL

//  Line-buffer controller and window sequencer for the 3x3 edge-detection MAC.

---
 rtl/edge_window_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/edge_window_ctrl.sv
// Line-buffer controller: stores a raster stream in four rotating lines and emits 3x3 windows, 1-cycle issue-to-valid latency.
// Backpressure: single output register, issue stalls while a window is held unaccepted; input stalls when all four lines are full.
module edge_window_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     in_pixel,
    input  logic                      in_pixel_valid,
    output logic                      in_ready,
    output logic [9*DATA_WIDTH-1:0]   out_window,
    output logic                      out_window_valid,
    input  logic                      out_ready,
    output logic                      o_intr
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] LAST_WR_COL = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] LAST_RD_COL = CW'(IMG_WIDTH - 3);

    typedef enum logic {
        IDLE,
        RD
    } stateT;

    stateT                   state;
    stateT                   stateNext;
    logic [1:0]              wrSel;
    logic [CW-1:0]           wrCol;
    logic [1:0]              rdSel;
    logic [CW-1:0]           rdCol;
    logic [2:0]              linesFull;
    logic                    accept;
    logic                    lineDone;
    logic                    issue;
    logic                    readDone;
    logic [9*DATA_WIDTH-1:0] nextWindow;

    logic [DATA_WIDTH-1:0]   lineBuf [4][IMG_WIDTH];

    assign in_ready = (linesFull != 3'd4);
    assign accept   = in_pixel_valid & in_ready;
    assign lineDone = accept && (wrCol == LAST_WR_COL);
    assign issue    = (state == RD) && (!out_window_valid || out_ready);
    assign readDone = issue && (rdCol == LAST_RD_COL);

    // Storage carries no reset: contents are meaningless until rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            lineBuf[wrSel][wrCol] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrSel <= 2'd0;
            wrCol <= '0;
        end else if (accept) begin
            if (lineDone) begin
                wrCol <= '0;
                wrSel <= wrSel + 2'd1;
            end else begin
                wrCol <= wrCol + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            linesFull <= 3'd0;
        end else begin
            case ({lineDone, readDone})
                2'b10:   linesFull <= linesFull + 3'd1;
                2'b01:   linesFull <= linesFull - 3'd1;
                default: linesFull <= linesFull;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Leaving RD always passes through IDLE, which samples the updated line count.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (linesFull >= 3'd3) stateNext = RD;
            RD:      if (readDone) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdSel <= 2'd0;
            rdCol <= '0;
        end else if (issue) begin
            if (readDone) begin
                rdCol <= '0;
                rdSel <= rdSel + 2'd1;
            end else begin
                rdCol <= rdCol + CW'(1);
            end
        end
    end

    // Row 0 is the oldest line; column 0 is the leftmost pixel of the window.
    for (genvar r = 0; r < 3; r++) begin : gRow
        logic [1:0] rowSel;
        assign rowSel = rdSel + 2'(r);
        for (genvar c = 0; c < 3; c++) begin : gCol
            logic [CW-1:0] colIdx;
            assign colIdx = rdCol + CW'(c);
            assign nextWindow[(3*r+c)*DATA_WIDTH +: DATA_WIDTH] = lineBuf[rowSel][colIdx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_window       <= '0;
            out_window_valid <= 1'b0;
            o_intr           <= 1'b0;
        end else begin
            o_intr <= readDone;
            if (issue) begin
                out_window       <= nextWindow;
                out_window_valid <= 1'b1;
            end else if (out_ready) begin
                out_window_valid <= 1'b0;
            end
        end
    end

endmodule
